regfile_mp: RTL

Parametrised multi-port general-purpose register file for the pipelined core, successor to the fixed 2R1W 32x32 file. Supports configurable width, depth, read and write ports, and write-to-read bypass. Includes a per-register pending scoreboard used by the hazard unit to stall consumers of in-flight results. Sits between ID (reads, issue) and WB (writes).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  // Architectural zero register: never written, never pending.
  localparam int REG_ZERO     = 0;

  // Address width for a register count; at least one bit so a 2-entry file still indexes.
  function automatic int regs_addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue, cleared on writeback.
// Issue beats writeback in the same cycle (a new producer replaces the retiring one).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = regs_addr_w(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     issue_valid_i,
  input  logic [ADDR_W-1:0]        issue_address_i,
  input  logic [NUM_WR-1:0]        write_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] write_address_i,
  input  logic [NUM_RD*ADDR_W-1:0] read_address_i,
  output logic [NUM_RD-1:0]        read_pending_o,
  output logic [NUM_REGS-1:0]      pending_vec_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decode issue/writeback into per-register set and clear, then apply set-over-clear priority.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid_i) set_vec[issue_address_i] = 1'b1;
    for (int w = 0; w < NUM_WR; w++) begin
      if (write_en_i[w]) clr_vec[write_address_i[w*ADDR_W +: ADDR_W]] = 1'b1;
    end
    set_vec[REG_ZERO] = 1'b0;
    clr_vec[REG_ZERO] = 1'b0;
    pend_d = set_vec | (pend_q & ~clr_vec);
  end

  // Pending bits, cleared asynchronously on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending_vec_o = pend_q;

  // Per-port lookup; with bypass a retiring write (and no re-issue) already satisfies the reader.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rp
    logic [ADDR_W-1:0] ra;
    assign ra = read_address_i[gi*ADDR_W +: ADDR_W];
    assign read_pending_o[gi] = pend_q[ra] &
                                ~((BYPASS != 0) && clr_vec[ra] && !set_vec[ra]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass and
// a pending-producer scoreboard. Optional stored parity: define REGFILE_PARITY_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = regs_addr_w(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] Read_address,
  output logic [NUM_RD*DATA_W-1:0] Read_data,
  output logic [NUM_RD-1:0]        Read_pending,
  input  logic [NUM_WR-1:0]        Write_en,
  input  logic [NUM_WR*ADDR_W-1:0] Write_address,
  input  logic [NUM_WR*DATA_W-1:0] Write_data,
  input  logic                     Issue_valid,
  input  logic [ADDR_W-1:0]        Issue_address,
`ifdef REGFILE_PARITY_EN
  output logic [NUM_RD-1:0]        Read_perr,
`endif
  output logic [NUM_REGS-1:0]      Pending_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] par_q;
  logic [NUM_REGS-1:0] par_d;
`endif

  // Apply enabled writes in port order so the highest port wins a same-address conflict.
  always_comb begin
    regs_d = regs_q;
`ifdef REGFILE_PARITY_EN
    par_d  = par_q;
`endif
    for (int w = 0; w < NUM_WR; w++) begin
      if (Write_en[w] && (Write_address[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
        regs_d[Write_address[w*ADDR_W +: ADDR_W]] = Write_data[w*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
        par_d[Write_address[w*ADDR_W +: ADDR_W]]  = ^Write_data[w*DATA_W +: DATA_W];
`endif
      end
    end
    regs_d[REG_ZERO] = '0;
`ifdef REGFILE_PARITY_EN
    par_d[REG_ZERO]  = 1'b0;
`endif
  end

  // Register storage, cleared asynchronously on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs_q <= '0;
`ifdef REGFILE_PARITY_EN
      par_q  <= '0;
`endif
    end else begin
      regs_q <= regs_d;
`ifdef REGFILE_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;
    logic              byp_hit;
    assign ra = Read_address[gi*ADDR_W +: ADDR_W];

    // Stored value, overridden by same-cycle write data when bypassing; r0 always reads 0.
    always_comb begin
      rd_val  = regs_q[ra];
      byp_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (Write_en[w] && (Write_address[w*ADDR_W +: ADDR_W] == ra)) begin
            rd_val  = Write_data[w*DATA_W +: DATA_W];
            byp_hit = 1'b1;
          end
        end
      end
      if (ra == ADDR_W'(REG_ZERO)) begin
        rd_val  = '0;
        byp_hit = 1'b1;
      end
    end

    assign Read_data[gi*DATA_W +: DATA_W] = rd_val;

`ifdef REGFILE_PARITY_EN
    // Only a stored value can be corrupt; forwarded data and r0 report clean.
    assign Read_perr[gi] = ~byp_hit & (par_q[ra] ^ (^regs_q[ra]));
`else
    logic unused_byp;
    assign unused_byp = byp_hit;
`endif
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .CLK             (CLK),
    .RST             (RST),
    .issue_valid_i   (Issue_valid),
    .issue_address_i (Issue_address),
    .write_en_i      (Write_en),
    .write_address_i (Write_address),
    .read_address_i  (Read_address),
    .read_pending_o  (Read_pending),
    .pending_vec_o   (Pending_vec)
  );

endmodule
